// File: rtl/result_drain.sv
// result_drain: captures a 4x4 matrix-multiply result and streams it out requantized.
// Optional macro RESULT_DRAIN_ROUND_EN selects round-half-up instead of truncation.
module result_drain #(
    parameter int OUT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [0:3][0:3][15:0] c_in,
    input  logic                  mm_done,
    input  logic [3:0]            shift,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_row,
    output logic [1:0]            out_col,
    output logic                  out_last,
    output logic                  busy,
    output logic [4:0]            sat_count,
    output logic                  overrun
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [16:0] MAX_Q = 17'((1 << OUT_W) - 1);

    state_t state, state_nxt;
    logic mm_done_q;
    logic [0:3][0:3][15:0] c_q;
    logic [3:0] shift_q;
    logic [1:0] row, col;
    logic capture, hs, is_last, sat;
    logic [16:0] q;

    assign capture = mm_done && !mm_done_q;
    assign hs      = (state == STREAM) && out_ready;
    assign is_last = (row == 2'd3) && (col == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (capture) state_nxt = STREAM;
            STREAM:  if (hs && is_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef RESULT_DRAIN_ROUND_EN
    logic [16:0] rnd;

    always_comb begin
        rnd = '0;
        if (shift_q != 4'd0) rnd = 17'd1 << (shift_q - 4'd1);
    end

    assign q = ({1'b0, c_q[row][col]} + rnd) >> shift_q;
`else
    assign q = {1'b0, c_q[row][col]} >> shift_q;
`endif

    assign sat       = q > MAX_Q;
    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_row   = row;
    assign out_col   = col;
    assign out_last  = out_valid && is_last;
    assign out_data  = !out_valid ? '0 :
                       sat ? MAX_Q[OUT_W-1:0] : q[OUT_W-1:0];

    // Index wraps 3,3 -> 0,0 on the final handshake, so IDLE always shows 0,0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_done_q <= 1'b0;
            c_q       <= '0;
            shift_q   <= '0;
            row       <= '0;
            col       <= '0;
            sat_count <= '0;
            overrun   <= 1'b0;
        end else begin
            mm_done_q <= mm_done;
            overrun   <= capture && (state == STREAM);
            if (capture && (state == IDLE)) begin
                c_q       <= c_in;
                shift_q   <= shift;
                row       <= '0;
                col       <= '0;
                sat_count <= '0;
            end else if (hs) begin
                if (sat) sat_count <= sat_count + 5'd1;
                col <= col + 2'd1;
                if (col == 2'd3) row <= row + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: vector table, directed corner sequences and random streams
// for result_drain, checked against an arithmetic requantization model.
module tb_result_drain;
    localparam int OUT_W = 8;
    localparam int MAXV  = (1 << OUT_W) - 1;
`ifdef RESULT_DRAIN_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [0:3][0:3][15:0] c_in;
    logic mm_done;
    logic [3:0] shift;
    logic [OUT_W-1:0] out_data;
    logic out_valid;
    logic out_ready;
    logic [1:0] out_row;
    logic [1:0] out_col;
    logic out_last;
    logic busy;
    logic [4:0] sat_count;
    logic overrun;

    int errors = 0;
    int checks = 0;
    int mat[4][4];

    typedef struct {
        int c;
        int sh;
        int exp_data;
        int exp_sat;
    } vec_t;

    vec_t tbl[6];

    result_drain #(.OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .c_in(c_in), .mm_done(mm_done),
        .shift(shift), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .busy(busy), .sat_count(sat_count),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int model(input int c, input int sh, output bit s);
        int r;
        int q;
        r = (RND && sh > 0) ? (1 << (sh - 1)) : 0;
        q = (c + r) >> sh;
        s = q > MAXV;
        return s ? MAXV : q;
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_row"}, out_row, 0);
        chk({tag, "_col"}, out_col, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sat"}, sat_count, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic load_mat();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c_in[i][j] = 16'(mat[i][j]);
    endtask

    task automatic rand_mat();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                mat[i][j] = int'($urandom_range(0, 65535));
    endtask

    // Leaves the bench at the negedge where beat 0 must be visible.
    task automatic fire(input int sh);
        mm_done   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        load_mat();
        shift   = 4'(sh);
        mm_done = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c_in[i][j] = 16'($urandom);
        shift = 4'($urandom);
    endtask

    // mode 0: ready always; 1: ready 1,0,0 repeating; 2: random ready;
    // 3: ready always with a dropped capture injected mid-stream.
    task automatic drain(input int sh, input int mode,
                         output int first, output int satc, output int cyc);
        int k;
        int exp_sat;
        int budget;
        int e;
        bit s;
        bit rdy;
        k = 0;
        exp_sat = 0;
        budget = 0;
        first = -1;
        while (k < 16 && budget < 200) begin
            e = model(mat[k / 4][k % 4], sh, s);
            chk("valid", out_valid, 1);
            chk("data", out_data, e);
            chk("row", out_row, k / 4);
            chk("col", out_col, k % 4);
            chk("last", out_last, int'(k == 15));
            chk("busy", busy, 1);
            if (k == 0 && first < 0) first = int'(out_data);
            if (mode == 3) begin
                chk("overrun", overrun, int'(k == 5));
                if (k == 3) mm_done = 1'b0;
                if (k == 4) begin
                    mm_done = 1'b1;
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++)
                            c_in[i][j] = 16'hffff;
                end
            end
            case (mode)
                1:       rdy = (budget % 3 == 0);
                2:       rdy = 1'($urandom);
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            @(negedge clk);
            budget++;
            if (rdy) begin
                if (s) exp_sat++;
                k++;
            end
        end
        if (k < 16) chk("drain_timeout", k, 16);
        chk("valid_after", out_valid, 0);
        chk("busy_after", busy, 0);
        chk("sat_count", sat_count, exp_sat);
        satc = int'(sat_count);
        cyc = budget;
    endtask

    initial begin
        int f;
        int s;
        int cyc;
        int e;
        bit sb;
        int sh;

        tbl[0] = '{32'h1234, 4, 255, 16};
        tbl[1] = '{32'h1234, 8, 18, 0};
        tbl[2] = '{32'h0018, 4, RND ? 2 : 1, 0};
        tbl[3] = '{32'h00ff, 0, 255, 0};
        tbl[4] = '{32'h0100, 0, 255, 16};
        tbl[5] = '{32'hffff, 15, RND ? 2 : 1, 0};

        rst_n = 1'b0;
        mm_done = 1'b0;
        out_ready = 1'b0;
        c_in = '0;
        shift = '0;
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_valid", out_valid, 0);

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                mat[i][j] = 16 * i + j;
        fire(0);
        drain(0, 0, f, s, cyc);
        chk("raster_cycles", cyc, 16);
        chk("raster_first", f, 0);
        chk("raster_sat", s, 0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    mat[i][j] = tbl[v].c;
            fire(tbl[v].sh);
            drain(tbl[v].sh, 0, f, s, cyc);
            chk("tbl_data", f, tbl[v].exp_data);
            chk("tbl_sat", s, tbl[v].exp_sat);
            out_ready = 1'b1;
            repeat (2) @(negedge clk);
            chk("idle_ready_valid", out_valid, 0);
            chk("sat_hold", sat_count, tbl[v].exp_sat);
        end

        rand_mat();
        sh = 3;
        fire(sh);
        drain(sh, 1, f, s, cyc);
        chk("pattern_cycles", cyc, 46);

        for (int n = 0; n < 8; n++) begin
            rand_mat();
            sh = int'($urandom_range(0, 15));
            fire(sh);
            drain(sh, 2, f, s, cyc);
        end

        rand_mat();
        sh = 6;
        fire(sh);
        drain(sh, 3, f, s, cyc);
        chk("overrun_clear", overrun, 0);

        rand_mat();
        sh = 2;
        fire(sh);
        for (int k = 0; k < 8; k++) begin
            e = model(mat[k / 4][k % 4], sh, sb);
            chk("pre_rst_data", out_data, e);
            if (k == 7) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outs("mid_rst");
            end else begin
                out_ready = 1'b1;
                @(negedge clk);
            end
        end
        mm_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_valid", out_valid, 0);
        end

        rst_n = 1'b0;
        rand_mat();
        load_mat();
        sh = 5;
        shift = 4'(sh);
        mm_done = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drain(sh, 2, f, s, cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 The block SHALL have parameter OUT_W, default 8, giving the output element width in bits (legal range 4..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port c_in, input, 16 bits x [0:3][0:3]: unsigned 4x4 matrix-multiply results.
REQ-005 The block SHALL have port mm_done, input, 1 bit: the multiplier's level done flag.
REQ-006 The block SHALL have port shift, input, 4 bits: the right-shift amount, sampled at capture.
REQ-007 The block SHALL have port out_data, output, OUT_W bits: the requantized element.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the element.
REQ-010 The block SHALL have port out_row and port out_col, output, 2 bits each: the index of the current element.
REQ-011 The block SHALL have port out_last, output, 1 bit: asserted with element [3][3].
REQ-012 The block SHALL have port busy, output, 1 bit: high while a matrix is held or streaming.
REQ-013 The block SHALL have port sat_count, output, 5 bits: the number of saturated elements (0..16) in the current or last matrix.
REQ-014 The block SHALL have port overrun, output, 1 bit: a one-cycle pulse on a dropped capture.

Function
REQ-015 The block SHALL keep a registered copy of mm_done and SHALL define the capture event as mm_done==1 with the previous-cycle mm_done==0.
REQ-016 The block SHALL have the states IDLE and STREAM; on a capture event in IDLE it SHALL latch all 16 c_in words and shift into internal registers in that same cycle, reset the element index to [0][0] and sat_count to 0, and enter STREAM.
REQ-017 The first out_valid SHALL rise in the cycle after the capture edge (latency 1 cycle).
REQ-018 In STREAM, out_valid SHALL be 1 and out_data, out_row, out_col and out_last SHALL be stable until a handshake (out_valid && out_ready).
REQ-019 Elements SHALL be emitted in raster order: col increments first, then row wraps col to 0.
REQ-020 On the handshake of [3][3] the block SHALL return to IDLE, and out_valid and busy SHALL be 0 in the next cycle.
REQ-021 Requantization SHALL compute q = (c + r) >> shift in 17-bit unsigned arithmetic, where r is defined in REQ-027/028.
REQ-022 out_data SHALL equal min(q, 2^OUT_W - 1).
REQ-023 sat_count SHALL increment by 1 at each handshake where q > 2^OUT_W - 1, and SHALL hold its final value in IDLE until the next capture.
REQ-024 A capture event while in STREAM SHALL NOT alter the held data, index or state, and SHALL pulse overrun high for exactly 1 cycle.
REQ-025 out_ready asserted while out_valid is 0 SHALL have no effect.
REQ-026 busy SHALL be 1 exactly when the state is STREAM.

Configuration
REQ-027 With macro RESULT_DRAIN_ROUND_EN defined, r SHALL be 2^(shift-1) when shift > 0 and 0 when shift == 0 (round half up).
REQ-028 With RESULT_DRAIN_ROUND_EN undefined, r SHALL be 0 (truncation), and no rounding adder SHALL be present.

Reset
REQ-029 While rst_n is 0, the block SHALL hold state IDLE, out_valid = 0, out_data = 0, out_row = 0, out_col = 0, out_last = 0, busy = 0, sat_count = 0, overrun = 0, and the registered copy of mm_done = 0.
REQ-030 Reset asserted mid-STREAM SHALL abandon the matrix immediately, and no element SHALL be emitted after release until a new capture event.
REQ-031 If mm_done is already 1 at reset release, the registered copy of mm_done SHALL be 0, so the first cycle after release is a capture event.

Verification
REQ-032 Load c_in[i][j] = 16*i + j, shift = 0, rise mm_done, hold out_ready = 1 -> out_data 0,1,2,3,16,...,51 on 16 consecutive cycles, first beat 1 cycle after the edge, out_last only on 51, busy then 0, sat_count = 0.
REQ-033 Set all c_in = 0x1234 and shift = 4 -> every element 0x123 saturates to 255 and sat_count = 16; with shift = 8 -> out_data = 0x12 and sat_count = 0.
REQ-034 ROUND_EN defined, c_in[0][0] = 0x0018, shift = 4 -> out_data = 2; ROUND_EN undefined, same stimulus -> out_data = 1.
REQ-035 out_ready toggles 1,0,0,1,... -> each element is held stable until accepted, no skips or duplicates, and the order is unchanged.
REQ-036 mm_done falls then rises again at beat 5 -> overrun pulses for 1 cycle and the stream completes with the original data; assert rst_n = 0 at beat 7 -> out_valid = 0 immediately and all outputs return to their reset values.
